// File: rtl/dma_copy_engine.sv
// dma_copy_engine: block-copy engine in front of a 1R1W synchronous data RAM.
// Copies `len` 16-bit words from src_addr.. to dst_addr.. at one word per cycle.
// The read issued in cycle k returns registered data in cycle k+1, where it is
// written through combinationally.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start                 transfer request, sampled only when idle
//   src_addr, dst_addr    first source / destination word address (latched on start)
//   len                   word count (latched on start); 0 gives a bare done pulse
//   busy, done            not-idle flag, one-cycle completion pulse
//   mem_dout_addr         RAM read address
//   mem_dout              RAM registered read data
//   we, mem_din_addr      RAM write enable / write address
//   mem_din               RAM write data
//   fill, fill_value      (DMA_FILL_EN only) write fill_value instead of copying
//
// Optional feature macro: DMA_FILL_EN.

`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 13
`endif

module dma_copy_engine #(
  parameter int unsigned ADDR_WIDTH = `DATA_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = `DATA_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
`ifdef DMA_FILL_EN
  input  logic                  fill,
  input  logic [15:0]           fill_value,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_dout_addr,
  input  logic [15:0]           mem_dout,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] mem_din_addr,
  output logic [15:0]           mem_din
);

  // One extra bit so len = 2^LEN_WIDTH-1 can be counted up to without overflow.
  localparam int unsigned CntWidth = LEN_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [CntWidth-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CntWidth-1:0]     wr_cnt_q, wr_cnt_d;
  logic                    rd_pend_q, rd_pend_d;  // a read was issued last cycle
  logic                    fill_mode;
  logic [15:0]             fill_data;
  logic [CntWidth-1:0]     len_ext;

  assign len_ext = {1'b0, len_q};

`ifdef DMA_FILL_EN
  logic        fill_q, fill_d;
  logic [15:0] fill_value_q, fill_value_d;

  assign fill_mode = fill_q;
  assign fill_data = fill_value_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q       <= 1'b0;
      fill_value_q <= 16'h0000;
    end else begin
      fill_q       <= fill_d;
      fill_value_q <= fill_value_d;
    end
  end

  always_comb begin
    fill_d       = fill_q;
    fill_value_d = fill_value_q;
    if (state_q == StIdle && start) begin
      fill_d       = fill;
      fill_value_d = fill_value;
    end
  end
`else
  assign fill_mode = 1'b0;
  assign fill_data = 16'h0000;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    rd_pend_d     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    mem_dout_addr = '0;
    we            = 1'b0;
    mem_din_addr  = '0;
    mem_din       = 16'h0000;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d    = src_addr;
          dst_d    = dst_addr;
          len_d    = len;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = (len == '0) ? StDone : StRun;
        end
      end

      StRun: begin
        busy = 1'b1;
        if (fill_mode) begin
          // No reads: a write every cycle starting in the first RUN cycle.
          we           = 1'b1;
          mem_din_addr = dst_q + ADDR_WIDTH'(wr_cnt_q);
          mem_din      = fill_data;
          wr_cnt_d     = wr_cnt_q + CntWidth'(1);
          if (wr_cnt_d == len_ext) state_d = StDone;
        end else begin
          if (rd_cnt_q < len_ext) begin
            mem_dout_addr = src_q + ADDR_WIDTH'(rd_cnt_q);
            rd_cnt_d      = rd_cnt_q + CntWidth'(1);
            rd_pend_d     = 1'b1;
          end
          if (rd_pend_q) begin
            we           = 1'b1;
            mem_din_addr = dst_q + ADDR_WIDTH'(wr_cnt_q);
            mem_din      = mem_dout;
            wr_cnt_d     = wr_cnt_q + CntWidth'(1);
            if (wr_cnt_d == len_ext) state_d = StDone;
          end
        end
      end

      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule
